// File: rtl/fractcam_pkg.sv
// +----------------------------------------------------------------------+
// | fractcam_pkg : shared FSM encodings and helpers for the fractcam path |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

package fractcam_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/andD2.sv
// +----------------------------------------------------------------------+
// | andD2 : D-bit two-input bitwise AND primitive                         |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module andD2 #(
  parameter int D = 64
) (
  input  logic [D-1:0] a,
  input  logic [D-1:0] b,
  output logic [D-1:0] y
);

  assign y = a & b;

endmodule

`default_nettype wire

// File: rtl/mvec_prio_enc.sv
// +----------------------------------------------------------------------+
// | mvec_prio_enc : lowest-set-bit index and any-hit flag of a D-bit vec  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mvec_prio_enc import fractcam_pkg::*; #(
  parameter  int D     = 64,
  localparam int IDX_W = clog2(D)
) (
  input  logic [D-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             hit
);

  // Scanning downward lets the lowest set bit be the last write.
  always_comb begin
    idx = '0;
    for (int i = D - 1; i >= 0; i--) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

  assign hit = |vec;

endmodule

`default_nettype wire

// File: rtl/mvec_and_seq.sv
// +----------------------------------------------------------------------+
// | mvec_and_seq : folds SEGS streamed match vectors through one shared   |
// |                AND stage into a single result with hit/index/tag     |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
`default_nettype none

module mvec_and_seq import fractcam_pkg::*; #(
  parameter  int D     = 64,
  parameter  int SEGS  = 4,
  parameter  int ID_W  = 8,
  localparam int IDX_W = clog2(D)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [D-1:0]     s_mvec,
  input  logic [ID_W-1:0]  s_id,
  input  logic             s_last,
  input  logic             s_valid,
  output logic             s_ready,
  output logic [D-1:0]     m_mvec,
  output logic             m_hit,
  output logic [IDX_W-1:0] m_idx,
  output logic [ID_W-1:0]  m_id,
  output logic             m_err,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int CNT_W = clog2(SEGS + 1);
  localparam logic [CNT_W-1:0] c_cnt_one  = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_segs = CNT_W'(SEGS);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [D-1:0]     r_acc;
  logic [D-1:0]     w_and;
  logic [D-1:0]     w_result;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [ID_W-1:0]  r_id;
  logic [ID_W-1:0]  w_id;
  logic             w_accept;
  logic             w_first;
  logic             w_full;
  logic             w_term;
  logic             w_err;

  assign s_ready  = (r_state != ST_OUT) || m_ready;
  assign w_accept = s_valid && s_ready;

  // Any beat taken outside ACC (IDLE, or OUT during a handshake) opens a search.
  assign w_first   = (r_state != ST_ACC);
  assign w_cnt_nxt = w_first ? c_cnt_one : r_cnt + c_cnt_one;
  assign w_full    = (w_cnt_nxt == c_cnt_segs);
  assign w_term    = s_last || w_full;
  assign w_err     = s_last != w_full;
  assign w_id      = w_first ? s_id : r_id;

  andD2 #(.D(D)) u_and (
    .a (r_acc),
    .b (s_mvec),
    .y (w_and)
  );

  assign w_result = w_first ? s_mvec : w_and;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (w_accept)                         w_state_nxt = w_term ? ST_OUT : ST_ACC;
    else if (r_state == ST_OUT && m_ready) w_state_nxt = ST_IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc   <= '0;
      r_cnt   <= '0;
      r_id    <= '0;
      m_mvec  <= '0;
      m_id    <= '0;
      m_err   <= 1'b0;
      m_valid <= 1'b0;
    end else begin
      if (r_state == ST_OUT && m_ready) m_valid <= 1'b0;
      if (w_accept) begin
        r_acc <= w_result;
        r_cnt <= w_cnt_nxt;
        r_id  <= w_id;
        if (w_term) begin
          m_mvec  <= w_err ? '0 : w_result;
          m_id    <= w_id;
          m_err   <= w_err;
          m_valid <= 1'b1;
        end
      end
    end
  end

  mvec_prio_enc #(.D(D)) u_prio (
    .vec (m_mvec),
    .idx (m_idx),
    .hit (m_hit)
  );

endmodule

`default_nettype wire

// File: doc/mvec_and_seq.md
# mvec_and_seq

Sequential match-vector reducer for the fractcam search path. Accepts one search's SEGS segment match vectors as a stream, one vector per beat. Folds them into a single D-bit result through one shared D-bit AND datapath, then presents the final vector with a hit flag and lowest matching entry index. Sits between the per-segment LUTRAM match slices and the CAM result/priority stage, replacing SEGS-1 parallel AND stages with one time-shared stage.

## Interface
- `D`, 64: match-vector width (CAM entries); multiple of 4, ≥4
- `SEGS`, 4: segments per search; ≥1
- `ID_W`, 8: search tag width
- `IDX_W`, `$clog2(D)`: localparam, not overridable
- `clk` in 1: single clock
- `rst_n` in 1: asynchronous, active-low reset
- `s_mvec` in D: segment match vector
- `s_id` in ID_W: search tag; sampled on first beat only
- `s_last` in 1: final segment of this search
- `s_valid` in 1: input beat valid
- `s_ready` out 1: input beat accepted when `s_valid && s_ready`
- `m_mvec` out D: reduced match vector
- `m_hit` out 1: `|m_mvec`
- `m_idx` out IDX_W: lowest set bit index of `m_mvec`; 0 when no hit
- `m_id` out ID_W: tag of the search
- `m_err` out 1: segment-count error for this search
- `m_valid` out 1: result valid
- `m_ready` in 1: result consumed when `m_valid && m_ready`

## Operation
- FSM states:
  - IDLE: awaiting first beat
  - ACC: accumulating
  - OUT: result held
- Accumulator `acc` (D bits) and beat counter `cnt` (0..SEGS).
- First beat, accepted in IDLE or on OUT→next: `acc ← s_mvec`, `id ← s_id`, `cnt ← 1`.
- Later beats: `acc ← acc & s_mvec` via the AND datapath, `cnt ← cnt+1`.
- Search terminates on the beat where `s_last==1` or where `cnt+1==SEGS`, whichever comes first.
- Error rule: `m_err=1` if the terminating beat has `s_last != (cnt+1==SEGS)`. This covers early `s_last` and missing `s_last` on beat SEGS.
  - On error, `m_mvec` is forced to 0, so `m_hit=0` and `m_idx=0`.
  - A missing `s_last` does not swallow later beats. The next beat starts a new search.
- On termination: `m_mvec ← result`, `m_id ← id`, `m_err`, `m_valid ← 1`, state → OUT.
- SEGS==1: every accepted beat terminates immediately, IDLE→OUT.
- `s_ready = (state != OUT) || m_ready`.
- OUT with `m_ready=1`:
  - If a beat is accepted in the same cycle, it becomes the first beat of the next search (state ACC, or OUT again when it terminates).
  - Otherwise state → IDLE and `m_valid ← 0`.
- OUT with `m_ready=0`: all `m_*` held stable and `s_ready=0`.
- `m_hit` and `m_idx` are combinational from registered `m_mvec` only.
- `acc` and `cnt` are not cleared between searches. They are overwritten on each first beat.

## Timing
- Reset values:
  - state IDLE, `cnt=0`, `acc=0`
  - `m_valid=0`, `m_mvec=0`, `m_id=0`, `m_err=0`
  - hence `m_hit=0`, `m_idx=0`
  - `s_ready=1` combinationally after reset
- Reset asserted mid-search or mid-OUT: partial search discarded, no result emitted.
- Latency: `m_valid` rises the cycle after the terminating beat is accepted.
- Throughput: one beat per cycle, including a first beat accepted on the same edge as an output handshake. Back-to-back searches need no bubble.
- `s_valid` may drop between beats of a search. ACC holds `acc` and `cnt` indefinitely.
- Critical paths:
  - `acc&s_mvec` → `m_mvec`: one AND level
  - priority encode: `m_mvec` → `m_idx` only

## Structure
- Shared package `fractcam_pkg`:
  - FSM state encodings (IDLE=2'd0, ACC=2'd1, OUT=2'd2)
  - `clog2` function used for IDX_W
- AND fold uses the team's existing D-bit `andD2` primitive, one instance with `a=acc` and `b=s_mvec`.
- One natural new sub-module, `mvec_prio_enc`: parameterised D→IDX_W lowest-set-bit encoder producing `m_idx` and `m_hit`.
- Target size is roughly 150–250 lines of RTL in the main module.

## Test plan
- D=64, SEGS=4, `m_ready=1`, id=0x5A; beats 0xFF00FF00_FFFFFFFF, 0xF000FFFF_0000FFFF, 0xFFFFFFFF_00F0FFFF, 0x10000000_000000F0 (last) → one cycle later `m_valid=1`, `m_mvec=0x10000000_000000F0`, `m_hit=1`, `m_idx=4`, `m_id=0x5A`, `m_err=0`.
- Four beats whose AND is zero → `m_mvec=0`, `m_hit=0`, `m_idx=0`, `m_err=0`.
- `s_last` on beat 2 → `m_err=1`, `m_mvec=0`, `m_hit=0`. A separate case with no `s_last` on beat 4 → `m_err=1` after beat 4, and the next beat starts a fresh search.
- `m_ready=0` for 5 cycles during OUT → `s_ready=0` and `m_*` stable throughout. Raising `m_ready` with `s_valid=1` accepts the next first beat in the same cycle.
- Continuous `s_valid` for 3 back-to-back searches with `m_ready=1` → 3 results spaced exactly 4 cycles apart, correct `m_id` each.
- `rst_n` pulsed low after beat 2 of a search → `m_valid` stays 0, and the next 4-beat search produces the correct result.
